multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder. A Moore/Mealy FSM sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It waits on a memory ready handshake with a bounded wait counter, adds a jump opcode, and traps on illegal opcodes or memory timeout instead of driving X. It sits between the instruction register opCode field and the shared-ALU/single-memory datapath.

---
 rtl/control_pkg.sv | 53 +++++
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle instruction controller.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_TRAP      = 4'd15
  } state_e;

  localparam int unsigned OP_R   = 32'd0;
  localparam int unsigned OP_LW  = 32'd1;
  localparam int unsigned OP_SW  = 32'd2;
  localparam int unsigned OP_BEQ = 32'd3;
  localparam int unsigned OP_J   = 32'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-state cycles without memReady and flags the timeout.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_WIDTH = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic mem_state_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  logic [WAIT_WIDTH-1:0] count_q;
  logic [WAIT_WIDTH-1:0] count_d;
  logic                  at_limit_s;

  assign at_limit_s = (count_q == WAIT_WIDTH'(WAIT_LIMIT));

  // Outside memory states the counter sits at zero, so every entry starts fresh.
  always_comb begin
    count_d = count_q;
    if (!mem_state_i || mem_ready_i) begin
      count_d = '0;
    end else if (!at_limit_s) begin
      count_d = count_q + WAIT_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A handshake on the limit cycle completes normally.
  assign timeout_o = mem_state_i && !mem_ready_i && at_limit_s;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller: sequences each instruction through fetch/decode/execute/mem/wb
// and traps on illegal opcodes or memory handshake timeout.
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int WAIT_LIMIT   = 15,
  parameter int WAIT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic                    zero,
  input  logic                    memReady,
  output logic                    pcWrite,
  output logic                    pcWriteCond,
  output logic                    iorD,
  output logic                    memRead,
  output logic                    memWrite,
  output logic                    irWrite,
  output logic                    memToReg,
  output logic                    regWrite,
  output logic                    regDst,
  output logic                    aluSrcA,
  output logic [1:0]              aluSrcB,
  output logic [1:0]              aluOp,
  output logic [1:0]              pcSource,
  output logic                    illegalOp,
  output logic                    memTimeout,
  output logic [3:0]              stateOut
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_out_s;
  logic   illegal_q;
  logic   illegal_d;
  logic   timeout_flag_q;
  logic   timeout_flag_d;
  logic   mem_state_s;
  logic   timeout_s;
  logic   unused_zero_s;

  // The zero flag gates pcWriteCond in the datapath, not here.
  assign unused_zero_s = zero;

  assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .WAIT_WIDTH (WAIT_WIDTH)
  ) u_timer (
    .clk_i       (clk),
    .reset_i     (reset),
    .mem_state_i (mem_state_s),
    .mem_ready_i (memReady),
    .timeout_o   (timeout_s)
  );

  // State and sticky trap flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_FETCH;
      illegal_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      illegal_q      <= illegal_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    ctrl_s         = '0;
    state_d        = state_q;
    illegal_d      = illegal_q;
    timeout_flag_d = timeout_flag_q;
    case (state_q)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.alu_op    = ALUOP_ADD;
        ctrl_s.pc_source = PCSRC_ALU;
        if (memReady) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          state_d         = S_DECODE;
        end else if (timeout_s) begin
          state_d        = S_TRAP;
          timeout_flag_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl_s.alu_src_b = SRCB_IMM_SH2;
        ctrl_s.alu_op    = ALUOP_ADD;
        case (opCode)
          OPCODE_WIDTH'(OP_R):   state_d = S_R_EXEC;
          OPCODE_WIDTH'(OP_LW):  state_d = S_MEM_ADDR;
          OPCODE_WIDTH'(OP_SW):  state_d = S_MEM_ADDR;
          OPCODE_WIDTH'(OP_BEQ): state_d = S_BRANCH;
          OPCODE_WIDTH'(OP_J):   state_d = S_JUMP;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
        if (opCode == OPCODE_WIDTH'(OP_LW)) begin
          state_d = S_MEM_READ;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.ior_d    = 1'b1;
        if (memReady) begin
          state_d = S_MEM_WB;
        end else if (timeout_s) begin
          state_d        = S_TRAP;
          timeout_flag_d = 1'b1;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.ior_d     = 1'b1;
        if (memReady) begin
          state_d = S_FETCH;
        end else if (timeout_s) begin
          state_d        = S_TRAP;
          timeout_flag_d = 1'b1;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_R_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REG;
        ctrl_s.alu_op    = ALUOP_FUNCT;
        state_d          = S_R_WB;
      end
      S_R_WB: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.reg_dst   = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = 1'b1;
        ctrl_s.alu_src_b     = SRCB_REG;
        ctrl_s.alu_op        = ALUOP_SUB;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_source     = PCSRC_ALUOUT;
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_source = PCSRC_JUMP;
        state_d          = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      // Unused encodings are treated as a fault and parked in TRAP.
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Reset masks every output so an abandoned instruction issues no strobes.
  assign ctrl_out_s  = reset ? '0 : ctrl_s;
  assign pcWrite     = ctrl_out_s.pc_write;
  assign pcWriteCond = ctrl_out_s.pc_write_cond;
  assign iorD        = ctrl_out_s.ior_d;
  assign memRead     = ctrl_out_s.mem_read;
  assign memWrite    = ctrl_out_s.mem_write;
  assign irWrite     = ctrl_out_s.ir_write;
  assign memToReg    = ctrl_out_s.mem_to_reg;
  assign regWrite    = ctrl_out_s.reg_write;
  assign regDst      = ctrl_out_s.reg_dst;
  assign aluSrcA     = ctrl_out_s.alu_src_a;
  assign aluSrcB     = ctrl_out_s.alu_src_b;
  assign aluOp       = ctrl_out_s.alu_op;
  assign pcSource    = ctrl_out_s.pc_source;
  assign illegalOp   = !reset && illegal_q;
  assign memTimeout  = !reset && timeout_flag_q;
  assign stateOut    = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [3:0] FE  = 4'd0;
  localparam logic [3:0] DE  = 4'd1;
  localparam logic [3:0] MA  = 4'd2;
  localparam logic [3:0] MR  = 4'd3;
  localparam logic [3:0] MWB = 4'd4;
  localparam logic [3:0] MWR = 4'd5;
  localparam logic [3:0] RE  = 4'd6;
  localparam logic [3:0] RW  = 4'd7;
  localparam logic [3:0] BR  = 4'd8;
  localparam logic [3:0] JP  = 4'd9;
  localparam logic [3:0] TR  = 4'd15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opCode = 6'd0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regWrite, regDst, aluSrcA, illegalOp, memTimeout;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] stateOut;

  int n_cmp = 0;
  int n_err = 0;
  string       name_q[$];
  logic [21:0] vec_q[$];

  multicycle_control #(
    .OPCODE_WIDTH (6),
    .WAIT_LIMIT   (15),
    .WAIT_WIDTH   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opCode      (opCode),
    .zero        (zero),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .memToReg    (memToReg),
    .regWrite    (regWrite),
    .regDst      (regDst),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSource    (pcSource),
    .illegalOp   (illegalOp),
    .memTimeout  (memTimeout),
    .stateOut    (stateOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-state output table, hand-transcribed from the state descriptions.
  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic rdy,
                                          input logic rst, input logic ill, input logic tmo);
    logic pw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa;
    logic [1:0] asb, aop, pcs;
    {pw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa} = 10'd0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      FE:  begin mr = 1'b1; asb = 2'b01; if (rdy) begin irw = 1'b1; pw = 1'b1; end end
      DE:  asb = 2'b11;
      MA:  begin asa = 1'b1; asb = 2'b10; end
      MR:  begin mr = 1'b1; iord = 1'b1; end
      MWB: begin rw = 1'b1; m2r = 1'b1; end
      MWR: begin mw = 1'b1; iord = 1'b1; end
      RE:  begin asa = 1'b1; aop = 2'b10; end
      RW:  begin rw = 1'b1; rd = 1'b1; end
      BR:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; end
      JP:  begin pw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    if (rst) return 22'd0;
    return {pw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa, asb, aop, pcs, ill, tmo, st};
  endfunction

  task automatic cyc(input string nm, input logic rst, input logic [5:0] opc, input logic z,
                     input logic rdy, input logic [3:0] st, input logic ill, input logic tmo);
    @(posedge clk);
    #1;
    reset    = rst;
    opCode   = opc;
    zero     = z;
    memReady = rdy;
    name_q.push_back(nm);
    vec_q.push_back(exp_vec(st, rdy, rst, ill, tmo));
  endtask

  // Monitor: every cycle presents a full control vector.
  initial begin
    string       nm;
    logic [21:0] ev;
    forever begin
      @(negedge clk);
      if (vec_q.size() > 0) begin
        nm = name_q.pop_front();
        ev = vec_q.pop_front();
        check(nm, {10'd0, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                   regWrite, regDst, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp,
                   memTimeout, stateOut}, {10'd0, ev});
      end
    end
  end

  initial begin
    cyc("rst_a", 1'b1, 6'd0, 1'b0, 1'b0, FE, 1'b0, 1'b0);
    cyc("rst_b", 1'b1, 6'd0, 1'b0, 1'b1, FE, 1'b0, 1'b0);
    check("cnt_after_reset", {24'd0, dut.u_timer.count_q}, 32'd0);

    // R-type; opCode junk outside DECODE must be ignored
    cyc("r_fetch",  1'b0, 6'h3F, 1'b0, 1'b1, FE, 1'b0, 1'b0);
    cyc("r_decode", 1'b0, 6'd0,  1'b0, 1'b1, DE, 1'b0, 1'b0);
    cyc("r_exec",   1'b0, 6'h2A, 1'b0, 1'b1, RE, 1'b0, 1'b0);
    cyc("r_wb",     1'b0, 6'h3F, 1'b0, 1'b1, RW, 1'b0, 1'b0);

    // LW with three wait cycles in MEM_READ
    cyc("lw_fetch",  1'b0, 6'd1, 1'b0, 1'b1, FE, 1'b0, 1'b0);
    cyc("lw_decode", 1'b0, 6'd1, 1'b0, 1'b1, DE, 1'b0, 1'b0);
    cyc("lw_addr",   1'b0, 6'd1, 1'b0, 1'b1, MA, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 1'b0, 6'h3F, 1'b0, 1'b0, MR, 1'b0, 1'b0);
    cyc("lw_rd_done", 1'b0, 6'h3F, 1'b0, 1'b1, MR,  1'b0, 1'b0);
    cyc("lw_wb",      1'b0, 6'h3F, 1'b0, 1'b0, MWB, 1'b0, 1'b0);

    // SW, minimum latency
    cyc("sw_fetch",  1'b0, 6'd2, 1'b0, 1'b1, FE,  1'b0, 1'b0);
    cyc("sw_decode", 1'b0, 6'd2, 1'b0, 1'b1, DE,  1'b0, 1'b0);
    cyc("sw_addr",   1'b0, 6'd2, 1'b0, 1'b1, MA,  1'b0, 1'b0);
    cyc("sw_write",  1'b0, 6'd2, 1'b0, 1'b1, MWR, 1'b0, 1'b0);

    // BEQ with zero=1 then zero=0: identical strobes
    cyc("beq1_fetch",  1'b0, 6'd3, 1'b1, 1'b1, FE, 1'b0, 1'b0);
    cyc("beq1_decode", 1'b0, 6'd3, 1'b1, 1'b1, DE, 1'b0, 1'b0);
    cyc("beq1_branch", 1'b0, 6'd3, 1'b1, 1'b1, BR, 1'b0, 1'b0);
    cyc("beq0_fetch",  1'b0, 6'd3, 1'b0, 1'b1, FE, 1'b0, 1'b0);
    cyc("beq0_decode", 1'b0, 6'd3, 1'b0, 1'b1, DE, 1'b0, 1'b0);
    cyc("beq0_branch", 1'b0, 6'd3, 1'b0, 1'b1, BR, 1'b0, 1'b0);

    // Jump
    cyc("j_fetch",  1'b0, 6'd4, 1'b0, 1'b1, FE, 1'b0, 1'b0);
    cyc("j_decode", 1'b0, 6'd4, 1'b0, 1'b1, DE, 1'b0, 1'b0);
    cyc("j_jump",   1'b0, 6'd0, 1'b0, 1'b1, JP, 1'b0, 1'b0);

    // Illegal opcode: TRAP held for 20 cycles, then reset
    cyc("ill_fetch",  1'b0, 6'h3F, 1'b0, 1'b1, FE, 1'b0, 1'b0);
    cyc("ill_decode", 1'b0, 6'h3F, 1'b0, 1'b1, DE, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc("ill_trap", 1'b0, 6'd0, 1'b0, 1'(i % 2), TR, 1'b1, 1'b0);
    cyc("ill_rst",  1'b1, 6'd0, 1'b0, 1'b0, TR, 1'b0, 1'b0);
    cyc("ill_rst2", 1'b1, 6'd0, 1'b0, 1'b0, FE, 1'b0, 1'b0);

    // Timeout in FETCH: counts 0..15 over 16 cycles, TRAP on the 17th
    for (int i = 0; i < 16; i++) cyc("to_wait", 1'b0, 6'd0, 1'b0, 1'b0, FE, 1'b0, 1'b0);
    check("cnt_at_limit", {24'd0, dut.u_timer.count_q}, 32'd15);
    cyc("to_trap", 1'b0, 6'd0, 1'b0, 1'b0, TR, 1'b0, 1'b1);
    cyc("to_rst",  1'b1, 6'd0, 1'b0, 1'b0, TR, 1'b0, 1'b0);

    // Handshake on the limit cycle wins
    for (int i = 0; i < 15; i++) cyc("hs_wait", 1'b0, 6'd0, 1'b0, 1'b0, FE, 1'b0, 1'b0);
    cyc("hs_limit_rdy", 1'b0, 6'd0, 1'b0, 1'b1, FE, 1'b0, 1'b0);
    check("cnt_hs_limit", {24'd0, dut.u_timer.count_q}, 32'd15);
    cyc("hs_decode", 1'b0, 6'd0, 1'b0, 1'b1, DE, 1'b0, 1'b0);
    cyc("hs_exec",   1'b0, 6'd0, 1'b0, 1'b1, RE, 1'b0, 1'b0);
    cyc("hs_wb",     1'b0, 6'd0, 1'b0, 1'b1, RW, 1'b0, 1'b0);

    // Reset during a stalled MEM_WRITE
    cyc("rsw_fetch",  1'b0, 6'd2, 1'b0, 1'b1, FE,  1'b0, 1'b0);
    cyc("rsw_decode", 1'b0, 6'd2, 1'b0, 1'b1, DE,  1'b0, 1'b0);
    cyc("rsw_addr",   1'b0, 6'd2, 1'b0, 1'b1, MA,  1'b0, 1'b0);
    cyc("rsw_wait0",  1'b0, 6'd2, 1'b0, 1'b0, MWR, 1'b0, 1'b0);
    cyc("rsw_wait1",  1'b0, 6'd2, 1'b0, 1'b0, MWR, 1'b0, 1'b0);
    cyc("rsw_reset",  1'b1, 6'd2, 1'b0, 1'b0, MWR, 1'b0, 1'b0);
    check("cnt_in_mw", {24'd0, dut.u_timer.count_q}, 32'd2);
    cyc("rsw_after",  1'b0, 6'd2, 1'b0, 1'b0, FE,  1'b0, 1'b0);
    check("cnt_post_rst", {24'd0, dut.u_timer.count_q}, 32'd0);
    cyc("rsw_fetch2", 1'b0, 6'd0, 1'b0, 1'b1, FE,  1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", vec_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
